// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter with registered one-hot grant and handover only at legal points.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  input  logic [NUM_MASTERS-1:0] hlock_i,
  input  logic [1:0]             htrans_i,
  input  logic [2:0]             hburst_i,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  output logic [3:0]             hmaster_o,
  output logic                   hmastlock_o
);

  localparam int unsigned          HoldW    = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0]     HoldMax  = HoldW'(MAX_HOLD);
  localparam logic [3:0]           DefIdx   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DefGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [1:0]           TrIdle   = 2'd0;
  localparam logic [1:0]           TrNonseq = 2'd2;
  localparam logic [1:0]           TrSeq    = 2'd3;

  typedef enum logic [1:0] {StPark, StGranted, StBurst, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             gidx_q, gidx_d, hmaster_q, winner, cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, arb_req;
  logic [HoldW-1:0]       hold_q, hold_d, hold_inc;
  logic                   hmastlock_q, retry_q, retry_d, rearb;
  logic                   any_req, others_req, owner_req, owner_lock, settled;

  // The granted master is the owner once hmaster has caught up with the grant.
  assign owner_req  = |(hbusreq_i & grant_q);
  assign owner_lock = |(hlock_i & grant_q);
  assign others_req = |(hbusreq_i & ~grant_q);
  assign any_req    = |hbusreq_i;
  assign settled    = (hmaster_q == gidx_q);
  assign hold_inc   = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;

`ifdef ARB_FIXED_PRIO_EN
  assign arb_req = hbusreq_i;

  always_comb begin
    winner = DefIdx;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (arb_req[i]) winner = 4'(i);
    end
  end
`else
  logic [3:0] rr_ptr_q;

  // A retried master sits out one round unless it is the only requester.
  assign arb_req = (retry_q && others_req) ? (hbusreq_i & ~grant_q) : hbusreq_i;

  always_comb begin
    int unsigned j;
    winner = DefIdx;
    for (int unsigned i = NUM_MASTERS; i >= 1; i--) begin
      j = (32'(rr_ptr_q) + i) % NUM_MASTERS;
      if (arb_req[j]) winner = j[3:0];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rr_ptr_q <= DefIdx;
    end else if (rearb && any_req) begin
      rr_ptr_q <= winner;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    retry_d = retry_q;
    rearb   = 1'b0;
    if (!hready_i) begin
      if (hresp_i != 2'd0) retry_d = 1'b1;
    end else begin
      retry_d = 1'b0;
      if (retry_q) begin
        rearb = 1'b1;
      end else begin
        unique case (state_q)
          StPark: rearb = any_req;
          StGranted: begin
            if (settled) begin
              if (owner_lock) begin
                state_d = StLocked;
              end else if (htrans_i == TrNonseq && hburst_i >= 3'd2) begin
                state_d = StBurst;
                cnt_d   = (hburst_i[2:1] == 2'd1) ? 4'd3 :
                          (hburst_i[2:1] == 2'd2) ? 4'd7 : 4'd15;
              end else if (htrans_i == TrIdle || !owner_req) begin
                rearb = 1'b1;
              end else if (htrans_i[1]) begin
                hold_d = hold_inc;
                rearb  = (hold_inc == HoldMax) && others_req;
              end
            end
          end
          StBurst: begin
            if (htrans_i == TrSeq) begin
              cnt_d = cnt_q - 4'd1;
              rearb = (cnt_q <= 4'd1);
            end else if (htrans_i == TrNonseq || htrans_i == TrIdle) begin
              rearb = 1'b1;
            end
          end
          StLocked: rearb = !owner_lock && (htrans_i == TrIdle || htrans_i == TrNonseq);
          default:  state_d = StPark;
        endcase
      end
      if (rearb) begin
        cnt_d = 4'd0;
        if (any_req) begin
          gidx_d  = winner;
          state_d = StGranted;
        end else begin
          gidx_d  = DefIdx;
          state_d = StPark;
        end
        if (gidx_d != gidx_q) hold_d = '0;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= StPark;
      gidx_q      <= DefIdx;
      grant_q     <= DefGrant;
      hmaster_q   <= DefIdx;
      hmastlock_q <= 1'b0;
      cnt_q       <= 4'd0;
      hold_q      <= '0;
      retry_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      grant_q <= NUM_MASTERS'(1) << gidx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      retry_q <= retry_d;
      if (hready_i) begin
        hmaster_q   <= gidx_q;
        hmastlock_q <= owner_lock;
      end
    end
  end

  assign hgrant_o    = grant_q;
  assign hmaster_o   = hmaster_q;
  assign hmastlock_o = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: vector table for round-robin alternation plus
// hand-written burst, lock, retry, hold-timer and async-reset sequences.
module tb_ahb_arbiter;
  localparam int unsigned N = 4;
  localparam logic [1:0] I = 2'd0, B = 2'd1, NS = 2'd2, S = 2'd3;

  logic         hclk = 1'b0;
  logic         hresetn = 1'b0;
  logic [N-1:0] hbusreq = '0, hlock = '0;
  logic [1:0]   htrans = I, hresp = 2'd0;
  logic [2:0]   hburst = 3'd0;
  logic         hready = 1'b1;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;
  int           errors = 0;
  int           checks = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .MAX_HOLD(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq_i(hbusreq), .hlock_i(hlock),
    .htrans_i(htrans), .hburst_i(hburst), .hready_i(hready), .hresp_i(hresp),
    .hgrant_o(hgrant), .hmaster_o(hmaster), .hmastlock_o(hmastlock)
  );

  typedef struct {
    logic [N-1:0] req;
    logic [1:0]   tr;
    logic         rdy;
    logic [N-1:0] g;
    logic [3:0]   m;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [N-1:0] g, input logic [3:0] m,
                           input logic l);
    check({name, " grant"}, 32'(hgrant), 32'(g));
    check({name, " master"}, 32'(hmaster), 32'(m));
    check({name, " lock"}, 32'(hmastlock), 32'(l));
  endtask

  task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy, input logic [1:0] rsp);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset(input string name);
    hresetn = 1'b0;
    hbusreq = '0; hlock = '0; htrans = I; hburst = 3'd0; hready = 1'b1; hresp = 2'd0;
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    check_out(name, 4'b0001, 4'd0, 1'b0);
  endtask

  initial begin
    logic [1:0] btr  [10];
    logic       brdy [10];

    // Masters 1 and 2 alternate on SINGLE transfers separated by IDLE.
    tbl[0]  = '{4'b0110, I,  1'b1, 4'b0010, 4'd0};
    tbl[1]  = '{4'b0110, I,  1'b1, 4'b0010, 4'd1};
    tbl[2]  = '{4'b0110, NS, 1'b1, 4'b0010, 4'd1};
    tbl[3]  = '{4'b0110, I,  1'b1, 4'b0100, 4'd1};
    tbl[4]  = '{4'b0110, I,  1'b1, 4'b0100, 4'd2};
    tbl[5]  = '{4'b0110, NS, 1'b1, 4'b0100, 4'd2};
    tbl[6]  = '{4'b0110, I,  1'b1, 4'b0010, 4'd2};
    tbl[7]  = '{4'b0110, I,  1'b1, 4'b0010, 4'd1};
    tbl[8]  = '{4'b0110, NS, 1'b1, 4'b0010, 4'd1};
    tbl[9]  = '{4'b0110, I,  1'b1, 4'b0100, 4'd1};
    tbl[10] = '{4'b0110, I,  1'b0, 4'b0100, 4'd1};
    tbl[11] = '{4'b0110, I,  1'b1, 4'b0100, 4'd2};
    tbl[12] = '{4'b0000, I,  1'b1, 4'b0001, 4'd2};
    tbl[13] = '{4'b0000, I,  1'b1, 4'b0001, 4'd0};

    do_reset("reset");
    for (int k = 0; k < 14; k++) begin
      cyc(tbl[k].req, '0, tbl[k].tr, 3'd0, tbl[k].rdy, 2'd0);
      check_out($sformatf("rr row %0d", k), tbl[k].g, tbl[k].m, 1'b0);
    end

    // Master 3 INCR8 with wait states and a BUSY; master 1 waits for the last beat.
    do_reset("reset burst");
    cyc(4'b1000, '0, I, 3'd0, 1'b1, 2'd0);
    check_out("burst grant3", 4'b1000, 4'd0, 1'b0);
    cyc(4'b1000, '0, I, 3'd0, 1'b1, 2'd0);
    check_out("burst own3", 4'b1000, 4'd3, 1'b0);
    cyc(4'b1010, '0, NS, 3'd5, 1'b1, 2'd0);
    check("burst start", 32'(hgrant), 32'(4'b1000));
    btr  = '{S, S, B, S, S, S, S, S, S, S};
    brdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 10; k++) begin
      cyc(4'b1010, '0, btr[k], 3'd5, brdy[k], 2'd0);
      check($sformatf("burst beat %0d", k), 32'(hgrant), (k == 9) ? 32'(4'b0010) : 32'(4'b1000));
    end
    cyc(4'b1010, '0, I, 3'd0, 1'b1, 2'd0);
    check("burst handover master", 32'(hmaster), 32'd1);

    // Master 2 locked through INCR4 and a SINGLE; master 0 waits for the unlocked NONSEQ.
    do_reset("reset lock");
    cyc(4'b0100, 4'b0100, I, 3'd0, 1'b1, 2'd0);
    check_out("lock grant2", 4'b0100, 4'd0, 1'b0);
    cyc(4'b0101, 4'b0100, I, 3'd0, 1'b1, 2'd0);
    check_out("lock own2", 4'b0100, 4'd2, 1'b1);
    cyc(4'b0101, 4'b0100, NS, 3'd3, 1'b1, 2'd0);
    check_out("lock incr4", 4'b0100, 4'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0101, 4'b0100, S, 3'd3, 1'b1, 2'd0);
      check_out($sformatf("lock seq %0d", k), 4'b0100, 4'd2, 1'b1);
    end
    cyc(4'b0101, 4'b0100, NS, 3'd0, 1'b1, 2'd0);
    check_out("lock single", 4'b0100, 4'd2, 1'b1);
    cyc(4'b0101, 4'b0100, I, 3'd0, 1'b1, 2'd0);
    check_out("lock idle held", 4'b0100, 4'd2, 1'b1);
    cyc(4'b0101, 4'b0000, NS, 3'd0, 1'b1, 2'd0);
    check_out("unlock nonseq", 4'b0001, 4'd2, 1'b0);
    cyc(4'b0101, 4'b0000, I, 3'd0, 1'b1, 2'd0);
    check_out("unlock own0", 4'b0001, 4'd0, 1'b0);

    // Two-cycle RETRY to master 1 with master 3 requesting.
    do_reset("reset retry");
    cyc(4'b0010, '0, I, 3'd0, 1'b1, 2'd0);
    cyc(4'b1010, '0, I, 3'd0, 1'b1, 2'd0);
    cyc(4'b1010, '0, NS, 3'd0, 1'b1, 2'd0);
    check_out("retry pre", 4'b0010, 4'd1, 1'b0);
    cyc(4'b1010, '0, NS, 3'd0, 1'b0, 2'd2);
    check_out("retry first cycle", 4'b0010, 4'd1, 1'b0);
    cyc(4'b1010, '0, I, 3'd0, 1'b1, 2'd2);
    check_out("retry second cycle", 4'b1000, 4'd1, 1'b0);
    cyc(4'b1010, '0, I, 3'd0, 1'b1, 2'd0);
    check_out("retry own3", 4'b1000, 4'd3, 1'b0);
    cyc(4'b1010, '0, NS, 3'd0, 1'b1, 2'd0);
    cyc(4'b1010, '0, I, 3'd0, 1'b1, 2'd0);
    check("retry regrant1", 32'(hgrant), 32'(4'b0010));

    // Master 0 continuous INCR, master 2 requesting: handover after 16 address phases.
    do_reset("reset hold");
    cyc(4'b0001, '0, I, 3'd0, 1'b1, 2'd0);
    check_out("hold park0", 4'b0001, 4'd0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      cyc(4'b0101, '0, (k == 1) ? NS : S, 3'd1, 1'b1, 2'd0);
      check($sformatf("hold phase %0d", k), 32'(hgrant), (k == 16) ? 32'(4'b0100) : 32'(4'b0001));
    end

    // Asynchronous reset mid-cycle returns to the parked default immediately.
    #2;
    hresetn = 1'b0;
    #1;
    check_out("async reset", 4'b0001, 4'd0, 1'b0);
    hresetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
